// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler
//   Periodic SPI ADC reader for the PID sensor path. Every SAMPLE_PERIOD
//   clocks one 16-bit mode-0 SPI frame is read (MSB first). 2^AVG_LOG2
//   consecutive samples are averaged, and the result is presented on
//   sens_data_o together with a RDY_HOLD-cycle level strobe.
// Ports
//   clk_in_i        system clock (only clock)
//   reset_n_i       asynchronous active-low reset
//   enable_i        run enable; low aborts any frame and idles
//   spi_miso_i      ADC serial data
//   spi_sclk_o      SPI clock, idle low
//   spi_cs_n_o      ADC chip select, active low
//   sens_data_o     averaged sample
//   sens_data_rdy_o new-data strobe
//   busy_o          frame in progress
//   overrun_o       sticky: tick arrived while busy (cleared by enable low)
module adc_spi_sampler #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 50000,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned RDY_HOLD      = 4
) (
  input  logic        clk_in_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic        spi_miso_i,
  output logic        spi_sclk_o,
  output logic        spi_cs_n_o,
  output logic [15:0] sens_data_o,
  output logic        sens_data_rdy_o,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam int unsigned TICK_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned RDY_W  = $clog2(RDY_HOLD + 1);
  localparam int unsigned ACC_W  = 16 + AVG_LOG2;
  localparam int unsigned CNT_W  = AVG_LOG2 + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [RDY_W-1:0]  RDY_LOAD  = RDY_W'(RDY_HOLD);
  localparam logic [CNT_W-1:0]  AVG_N     = CNT_W'(1 << AVG_LOG2);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_ACCUM} state_e;

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [4:0]        phase_q, phase_d;
  logic [15:0]       shift_q, shift_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       data_q, data_d;
  logic [RDY_W-1:0]  rdy_cnt_q, rdy_cnt_d;
  logic              rdy_q, rdy_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic              tick;
  logic              div_done;
  logic [ACC_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  cnt_inc;

  always_comb begin
    state_d   = state_q;
    div_d     = '0;
    phase_d   = phase_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    overrun_d = overrun_q;

    tick     = enable_i && (tick_q == TICK_LAST);
    div_done = (div_q == DIV_LAST);
    acc_sum  = acc_q + ACC_W'(shift_q);
    cnt_inc  = cnt_q + CNT_W'(1);

    tick_d    = (!enable_i || tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
    rdy_cnt_d = (rdy_cnt_q != '0) ? rdy_cnt_q - RDY_W'(1) : '0;

    if (!enable_i) begin
      // Abort: the ready strobe timer and sens_data are left untouched.
      state_d   = S_IDLE;
      cs_n_d    = 1'b1;
      sclk_d    = 1'b0;
      phase_d   = '0;
      shift_d   = '0;
      acc_d     = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else begin
      if (tick && state_q != S_IDLE) overrun_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            state_d = S_SETUP;
            cs_n_d  = 1'b0;
          end
        end
        S_SETUP: begin
          div_d = div_done ? '0 : div_q + DIV_W'(1);
          if (div_done) begin
            state_d = S_SHIFT;
            sclk_d  = 1'b1;
            phase_d = '0;
          end
        end
        S_SHIFT: begin
          // 32 half-periods; even phases are SCLK high. Sample at the start
          // of each high phase, which is the cycle SCLK rose.
          div_d = div_done ? '0 : div_q + DIV_W'(1);
          if (div_q == '0 && !phase_q[0]) shift_d = {shift_q[14:0], spi_miso_i};
          if (div_done) begin
            if (phase_q == 5'd31) begin
              state_d = S_HOLD;
              sclk_d  = 1'b0;
            end else begin
              phase_d = phase_q + 5'd1;
              sclk_d  = ~sclk_q;
            end
          end
        end
        S_HOLD: begin
          div_d = div_done ? '0 : div_q + DIV_W'(1);
          if (div_done) begin
            state_d = S_ACCUM;
            cs_n_d  = 1'b1;
          end
        end
        S_ACCUM: begin
          state_d = S_IDLE;
          if (cnt_inc == AVG_N) begin
            data_d    = 16'(acc_sum >> AVG_LOG2);
            rdy_cnt_d = RDY_LOAD;
            acc_d     = '0;
            cnt_d     = '0;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_inc;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    rdy_d  = (rdy_cnt_d != '0);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      div_q     <= '0;
      phase_q   <= '0;
      shift_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      rdy_cnt_q <= '0;
      rdy_q     <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      rdy_cnt_q <= rdy_cnt_d;
      rdy_q     <= rdy_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign spi_sclk_o      = sclk_q;
  assign spi_cs_n_o      = cs_n_q;
  assign sens_data_o     = data_q;
  assign sens_data_rdy_o = rdy_q;
  assign busy_o          = busy_q;
  assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler. Three instances share clock and reset:
//   0: CLK_DIV=4 SAMPLE_PERIOD=200 AVG_LOG2=0 (single-sample path, abort, reset)
//   1: CLK_DIV=4 SAMPLE_PERIOD=200 AVG_LOG2=2 (averaging)
//   2: CLK_DIV=4 SAMPLE_PERIOD=100 AVG_LOG2=0 (overrun)
// Expected strobe values for instances 0/1 are queued by the stimulus and
// popped by a monitor on each rising edge of sens_data_rdy_o.
module tb_adc_spi_sampler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en       [3];
  logic        miso     [3];
  logic        sclk     [3];
  logic        cs_n     [3];
  logic        rdy      [3];
  logic        busy     [3];
  logic        ovr      [3];
  logic [15:0] data     [3];
  logic [15:0] adc_word [3];

  int checks = 0;
  int errors = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  logic [15:0] tbl_b [12] = '{16'd100, 16'd200, 16'd300, 16'd401,
                              16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                              16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] exp_b [3]  = '{16'd250, 16'hFFFF, 16'h0000};

  always #5 clk = ~clk;

  adc_spi_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(200), .AVG_LOG2(0), .RDY_HOLD(4)) dut_a (
    .clk_in_i(clk), .reset_n_i(rst_n), .enable_i(en[0]), .spi_miso_i(miso[0]),
    .spi_sclk_o(sclk[0]), .spi_cs_n_o(cs_n[0]), .sens_data_o(data[0]),
    .sens_data_rdy_o(rdy[0]), .busy_o(busy[0]), .overrun_o(ovr[0]));

  adc_spi_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(200), .AVG_LOG2(2), .RDY_HOLD(4)) dut_b (
    .clk_in_i(clk), .reset_n_i(rst_n), .enable_i(en[1]), .spi_miso_i(miso[1]),
    .spi_sclk_o(sclk[1]), .spi_cs_n_o(cs_n[1]), .sens_data_o(data[1]),
    .sens_data_rdy_o(rdy[1]), .busy_o(busy[1]), .overrun_o(ovr[1]));

  adc_spi_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(100), .AVG_LOG2(0), .RDY_HOLD(4)) dut_c (
    .clk_in_i(clk), .reset_n_i(rst_n), .enable_i(en[2]), .spi_miso_i(miso[2]),
    .spi_sclk_o(sclk[2]), .spi_cs_n_o(cs_n[2]), .sens_data_o(data[2]),
    .sens_data_rdy_o(rdy[2]), .busy_o(busy[2]), .overrun_o(ovr[2]));

  // Mode-0 ADC: word latched when CS falls, bit 15 driven first, next bit
  // driven after each SCLK falling edge.
  for (genvar g = 0; g < 3; g++) begin : g_adc
    logic [15:0] lat = '0;
    logic [3:0]  bit_i = 4'd15;
    bit          active = 1'b0;
    always @(cs_n[g] or negedge sclk[g]) begin
      if (cs_n[g] !== 1'b0) begin
        active = 1'b0;
        bit_i  = 4'd15;
      end else if (!active) begin
        active = 1'b1;
        lat    = adc_word[g];
        bit_i  = 4'd15;
      end else if (bit_i != 4'd0) begin
        bit_i = bit_i - 4'd1;
      end
    end
    assign miso[g] = lat[bit_i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for CS to fall, then counts CS-low cycles and SCLK rises.
  // Returns at the first negedge with CS high again (the ACCUM cycle).
  task automatic wait_frame(input int g, output int waited, output int len, output int rises);
    bit prev;
    waited = 0;
    len    = 0;
    rises  = 0;
    prev   = 1'b0;
    while (cs_n[g] && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    while (!cs_n[g] && len < 2000) begin
      if (sclk[g] && !prev) rises++;
      prev = sclk[g];
      @(negedge clk);
      len++;
    end
  endtask

  task automatic wait_rises(input int g, input int k, output int got);
    bit prev;
    int n;
    prev = 1'b0;
    n    = 0;
    got  = 0;
    while (got < k && n < 2000) begin
      @(negedge clk);
      n++;
      if (sclk[g] && !prev) got++;
      prev = sclk[g];
    end
  endtask

  task automatic monitor(input int g);
    bit          prev;
    int          hold;
    logic [15:0] e;
    prev = 1'b0;
    hold = 0;
    forever begin
      @(negedge clk);
      if (rdy[g] && !prev) begin
        if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL strobe%0d_unexpected: got data 0x%0h expected no strobe", g, data[g]);
        end else begin
          e = (g == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("strobe%0d_data", g), data[g], e);
        end
        hold = 1;
      end else if (rdy[g]) begin
        hold++;
      end else if (prev) begin
        chk($sformatf("strobe%0d_len", g), hold, 4);
      end
      prev = rdy[g];
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, len, ris, got, falls, run, maxlow;
    bit pc;
    for (int i = 0; i < 3; i++) begin
      en[i]       = 1'b0;
      adc_word[i] = 16'h0000;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n[0], 1);
    chk("rst_sclk", sclk[0], 0);
    chk("rst_data", data[0], 0);
    chk("rst_rdy", rdy[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_ovr", ovr[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single sample, AVG_LOG2=0
    adc_word[0] = 16'hA5C3;
    q0.push_back(16'hA5C3);
    en[0] = 1'b1;
    wait_frame(0, w, len, ris);
    chk("a1_first_tick", w, 200);
    chk("a1_cs_len", len, 136);
    chk("a1_rises", ris, 16);
    chk("a1_accum_busy", busy[0], 1);
    chk("a1_accum_rdy", rdy[0], 0);
    @(negedge clk);
    chk("a1_busy_after", busy[0], 0);
    chk("a1_rdy_after", rdy[0], 1);
    chk("a1_data", data[0], 16'hA5C3);

    adc_word[0] = 16'h1234;
    q0.push_back(16'h1234);
    wait_frame(0, w, len, ris);
    chk("a2_period", w, 63);
    chk("a2_cs_len", len, 136);
    repeat (8) @(negedge clk);
    chk("a2_data", data[0], 16'h1234);

    // Abort after the 5th SCLK rise
    adc_word[0] = 16'h5A5A;
    wait_rises(0, 5, got);
    chk("ab_rises", got, 5);
    en[0] = 1'b0;
    @(negedge clk);
    chk("ab_cs_n", cs_n[0], 1);
    chk("ab_sclk", sclk[0], 0);
    chk("ab_busy", busy[0], 0);
    repeat (300) @(negedge clk);
    chk("ab_data_kept", data[0], 16'h1234);
    chk("ab_rdy", rdy[0], 0);
    en[0] = 1'b1;
    q0.push_back(16'h5A5A);
    wait_frame(0, w, len, ris);
    chk("ab_restart_tick", w, 200);
    chk("ab_cs_len", len, 136);
    chk("ab_rises2", ris, 16);
    repeat (8) @(negedge clk);
    chk("ab_data_new", data[0], 16'h5A5A);

    // Asynchronous reset mid-SHIFT, between clock edges
    adc_word[0] = 16'h0F0F;
    wait_rises(0, 3, got);
    chk("rs_rises", got, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_cs_n", cs_n[0], 1);
    chk("rs_sclk", sclk[0], 0);
    chk("rs_busy", busy[0], 0);
    chk("rs_data", data[0], 0);
    chk("rs_rdy", rdy[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q0.push_back(16'h0F0F);
    wait_frame(0, w, len, ris);
    chk("rs_first_tick", w, 200);
    chk("rs_cs_len", len, 136);
    chk("rs_rises2", ris, 16);
    repeat (8) @(negedge clk);
    chk("rs_data_new", data[0], 16'h0F0F);
    chk("a_no_overrun", ovr[0], 0);
    en[0] = 1'b0;

    // Averaging, AVG_LOG2=2
    en[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      adc_word[1] = tbl_b[i];
      if (i % 4 == 0) q1.push_back(exp_b[i / 4]);
      wait_frame(1, w, len, ris);
      chk($sformatf("b%0d_cs_len", i), len, 136);
      chk($sformatf("b%0d_rises", i), ris, 16);
      @(negedge clk);
      chk($sformatf("b%0d_rdy", i), rdy[1], (i % 4 == 3));
      if (i % 4 == 3) chk($sformatf("b%0d_data", i), data[1], exp_b[i / 4]);
    end
    en[1] = 1'b0;
    repeat (8) @(negedge clk);

    // Overrun: 136-cycle frames with a 100-cycle tick period
    adc_word[2] = 16'h3C3C;
    en[2]  = 1'b1;
    falls  = 0;
    run    = 0;
    maxlow = 0;
    pc     = 1'b1;
    for (int n = 1; n <= 1050; n++) begin
      @(negedge clk);
      if (!cs_n[2] && pc) falls++;
      pc = cs_n[2];
      run = cs_n[2] ? 0 : run + 1;
      if (run > maxlow) maxlow = run;
      if (n == 150) chk("c_ovr_early", ovr[2], 0);
    end
    chk("c_frames", falls, 5);
    chk("c_max_cs_low", maxlow, 136);
    chk("c_ovr_set", ovr[2], 1);
    chk("c_data", data[2], 16'h3C3C);
    en[2] = 1'b0;
    @(negedge clk);
    chk("c_ovr_clear", ovr[2], 0);

    repeat (10) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
